// File: rtl/result_bcd_display.sv
// ---------------------------------------------------------------------------
// result_bcd_display
//
// Output stage behind the 8-bit adder/subtractor.
//
// On a start pulse it captures the result and the overflow flag. It then
// converts the result to a sign flag plus three BCD digits, using a
// shift-add-3 (double-dabble) engine that handles one bit per clock. The
// finished digits are held in registers for the 7-segment driver.
//
// Parameters
//   SIGNED   1: s is two's complement (-128..127)
//            0: s is unsigned (0..255)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   start     in   conversion request, sampled only in IDLE
//   s[7:0]    in   adder result, sampled on the accepting edge
//   overflow  in   adder overflow flag, sampled together with s
//   busy      out  high while a conversion is running (SHIFT or DONE)
//   done      out  one-cycle pulse; the digits are valid from this cycle on
//   sign      out  1 = negative result (always 0 when SIGNED=0)
//   err       out  overflow flag that belongs to the displayed result
//   hundreds  out  BCD hundreds digit, 0..2
//   tens      out  BCD tens digit, 0..9
//   ones      out  BCD ones digit, 0..9
// ---------------------------------------------------------------------------
module result_bcd_display #(
   parameter bit SIGNED = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] s,
   input  logic       overflow,
   output logic       busy,
   output logic       done,
   output logic       sign,
   output logic       err,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  mag_q, mag_d;     // magnitude, shifted out MSB first
   logic        neg_q, neg_d;     // captured sign of the running conversion
   logic        ovf_q, ovf_d;     // captured overflow of the running conversion
   logic [11:0] bcd_q, bcd_d;     // BCD scratch register
   logic [2:0]  cnt_q, cnt_d;     // shift counter
   logic        sign_q, sign_d;
   logic        err_q, err_d;
   logic [3:0]  hund_q, hund_d;
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  ones_q, ones_d;

   // Combinational results for one double-dabble step.
   logic [11:0] bcd_adj;
   logic [19:0] shift_val;
   logic        in_neg;
   logic [7:0]  in_mag;

   // Add 3 to every nibble that is >= 5. All three nibbles are corrected
   // in parallel, before the shift.
   for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 :
                                  bcd_q[gi*4 +: 4];
   end

   // Shift {bcd, magnitude} left by one. The top bit of the corrected BCD
   // is always 0, because the largest value we handle is 255.
   assign shift_val = {bcd_adj[10:0], mag_q, 1'b0};

   // Negating 0x80 gives 0x80. Read as unsigned, that is 128, which is the
   // correct magnitude.
   assign in_neg = SIGNED && s[7];
   assign in_mag = in_neg ? (~s + 8'd1) : s;

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      err_d   = err_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               mag_d   = in_mag;
               neg_d   = in_neg;
               ovf_d   = overflow;
               bcd_d   = 12'd0;
               cnt_d   = 3'd0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bcd_d = shift_val[19:8];
            mag_d = shift_val[7:0];
            cnt_d = cnt_q + 3'd1;
            // On the last shift, load the displayed digits straight from
            // the shifter output. The outputs never show partial values.
            if (cnt_q == 3'd7) begin
               hund_d  = shift_val[19:16];
               tens_d  = shift_val[15:12];
               ones_d  = shift_val[11:8];
               sign_d  = neg_q;
               err_d   = ovf_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mag_q   <= 8'd0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         bcd_q   <= 12'd0;
         cnt_q   <= 3'd0;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
         hund_q  <= 4'd0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         err_q   <= err_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign sign     = sign_q;
   assign err      = err_q;
   assign hundreds = hund_q;
   assign tens     = tens_q;
   assign ones     = ones_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// ---------------------------------------------------------------------------
// tb_result_bcd_display
//
// Directed test of result_bcd_display. It drives one SIGNED=1 instance and
// one SIGNED=0 instance. Each conversion pushes its expected result into a
// queue; the entry is popped and compared when done is seen.
// ---------------------------------------------------------------------------
module tb_result_bcd_display;

   typedef struct packed {
      logic       sign;
      logic       err;
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] o;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s, ov_s, start_u, ov_u;
   logic [7:0] s_s, s_u;
   logic       busy_s, done_s, sign_s, err_s;
   logic       busy_u, done_u, sign_u, err_u;
   logic [3:0] h_s, t_s, o_s, h_u, t_u, o_u;

   int   total  = 0;
   int   passed = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   result_bcd_display #(.SIGNED(1'b1)) u_signed (
      .clk(clk), .rst(rst), .start(start_s), .s(s_s), .overflow(ov_s),
      .busy(busy_s), .done(done_s), .sign(sign_s), .err(err_s),
      .hundreds(h_s), .tens(t_s), .ones(o_s)
   );

   result_bcd_display #(.SIGNED(1'b0)) u_unsigned (
      .clk(clk), .rst(rst), .start(start_u), .s(s_u), .overflow(ov_u),
      .busy(busy_u), .done(done_u), .sign(sign_u), .err(err_u),
      .hundreds(h_u), .tens(t_u), .ones(o_u)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic exp_t model(input bit uns, input logic [7:0] v, input logic ov);
      exp_t e;
      int   m;
      bit   neg;
      neg    = !uns && v[7];
      m      = neg ? 256 - int'(v) : int'(v);
      e.sign = neg;
      e.err  = ov;
      e.h    = 4'(m / 100);
      e.t    = 4'((m / 10) % 10);
      e.o    = 4'(m % 10);
      return e;
   endfunction

   function automatic exp_t dut_out(input bit uns);
      exp_t e;
      if (uns) e = '{sign_u, err_u, h_u, t_u, o_u};
      else     e = '{sign_s, err_s, h_s, t_s, o_s};
      return e;
   endfunction

   task automatic drive(input bit uns, input logic st, input logic [7:0] v, input logic ov);
      if (uns) begin start_u = st; s_u = v; ov_u = ov; end
      else     begin start_s = st; s_s = v; ov_s = ov; end
   endtask

   // One conversion. gat > 0 pulses start again, with value gs, at edge k+gat.
   task automatic run(input bit uns, input logic [7:0] sv, input logic ov,
                      input int gat, input logic [7:0] gs, input string tag);
      exp_t e, got;
      int   n;
      logic [7:0] scramble;
      scramble = sv ^ 8'hA5;
      @(negedge clk);
      drive(uns, 1'b1, sv, ov);
      sb.push_back(model(uns, sv, ov));
      @(negedge clk);                       // edge k has passed
      n = 0;
      while (n < 20 && !(uns ? done_u : done_s)) begin
         chk({tag, "_busy"}, 16'(uns ? busy_u : busy_s), 16'd1);
         if (gat > 0 && n == gat - 1) drive(uns, 1'b1, gs, 1'b0);
         else                         drive(uns, 1'b0, scramble, !ov);
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 16'(n), 16'd8);
      chk({tag, "_busy_done"}, 16'(uns ? busy_u : busy_s), 16'd1);
      got = dut_out(uns);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_result"}, 16'(got), 16'(e));
         $display("conv %s: s=%02h ov=%0b -> sign=%0b err=%0b %0d%0d%0d (cycles=%0d)",
                  tag, sv, ov, got.sign, got.err, got.h, got.t, got.o, n);
      end else begin
         chk({tag, "_sb_empty"}, 16'd0, 16'd1);
      end
      drive(uns, 1'b0, scramble, 1'b0);
      @(negedge clk);                       // edge k+9 has passed
      chk({tag, "_done_1cyc"}, 16'(uns ? done_u : done_s), 16'd0);
      chk({tag, "_idle"}, 16'(uns ? busy_u : busy_s), 16'd0);
   endtask

   initial begin
      int pulses;
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      chk("reset_signed", 16'({busy_s, done_s, sign_s, err_s, h_s, t_s, o_s}), 16'd0);
      chk("reset_unsigned", 16'({busy_u, done_u, sign_u, err_u, h_u, t_u, o_u}), 16'd0);
      rst = 1'b0;

      run(1'b0, 8'h7B, 1'b0, 0, 8'h00, "s_7B");
      run(1'b0, 8'hFF, 1'b0, 0, 8'h00, "s_FF");
      run(1'b0, 8'h80, 1'b0, 0, 8'h00, "s_80");
      run(1'b1, 8'hFF, 1'b0, 0, 8'h00, "u_FF");
      run(1'b1, 8'h00, 1'b0, 0, 8'h00, "u_00");
      run(1'b0, 8'h82, 1'b1, 0, 8'h00, "s_82_ovf");
      run(1'b0, 8'h05, 1'b0, 0, 8'h00, "s_05");
      run(1'b0, 8'h2A, 1'b0, 3, 8'h11, "s_2A_restart");

      // A start pulse in the middle of a conversion must not begin a second one.
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_s) pulses++;
      end
      chk("restart_ignored", 16'(pulses), 16'd0);
      $display("restart window: done pulses=%0d", pulses);

      // Reset during SHIFT aborts the conversion.
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h63, 1'b0);
      @(negedge clk);                       // edge k
      drive(1'b0, 1'b0, 8'h63, 1'b0);
      repeat (3) @(negedge clk);            // edges k+1..k+3
      rst = 1'b1;
      @(negedge clk);                       // edge k+4 with rst asserted
      chk("abort_outputs",
          16'({busy_s, done_s, sign_s, err_s, h_s, t_s, o_s}), 16'd0);
      rst = 1'b0;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_s) pulses++;
      end
      chk("abort_no_done", 16'(pulses), 16'd0);
      $display("abort: done pulses after reset=%0d", pulses);

      run(1'b0, 8'h63, 1'b0, 0, 8'h00, "s_63_after_rst");

      chk("sb_drained", 16'(sb.size()), 16'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
